// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: double-buffered scan controller for a 4-digit 7-segment display and an 8x8 LED matrix.
module display_scan_ctrl #(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int SCAN_RATE = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        CLOCK_IN,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        commit,
    output logic        pending,
    output logic        frame_done,
    output logic [2:0]  slot,
    output logic [11:0] LED,
    output logic [7:0]  ROW_LED,
    output logic [7:0]  COL_LED
);
    localparam int SLOT_CYC = CLOCK_FREQUENCY / SCAN_RATE;
    localparam int CW = $clog2(SLOT_CYC);
    localparam logic [15:0][7:0] SEG = {8'h8E, 8'h86, 8'hA1, 8'hA7, 8'h83, 8'h88, 8'h90, 8'h80,
                                        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    typedef enum logic {BLANK, SHOW} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] slot_q, slot_d;
    logic pending_q, pending_d, frame_done_q, frame_done_d;
    logic [11:0] led_q, led_d;
    logic [7:0] row_q, row_d, col_q, col_d;
    logic [5:0] sh_dig_q [4], sh_dig_d [4], ac_dig_q [4], ac_dig_d [4];
    logic [7:0] sh_col_q [8], sh_col_d [8], ac_col_q [8], ac_col_d [8];
    logic last, boundary;
    logic [5:0] dig;
    always_ff @(posedge CLOCK_IN) begin
        if (reset) begin
            state_q <= BLANK;
            cnt_q <= '0;
            slot_q <= '0;
            pending_q <= 1'b0;
            frame_done_q <= 1'b0;
            led_q <= 12'hFFF;
            row_q <= 8'hFF;
            col_q <= 8'hFF;
            sh_dig_q <= '{default: 6'h20};
            ac_dig_q <= '{default: 6'h20};
            sh_col_q <= '{default: 8'h00};
            ac_col_q <= '{default: 8'h00};
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            slot_q <= slot_d;
            pending_q <= pending_d;
            frame_done_q <= frame_done_d;
            led_q <= led_d;
            row_q <= row_d;
            col_q <= col_d;
            sh_dig_q <= sh_dig_d;
            ac_dig_q <= ac_dig_d;
            sh_col_q <= sh_col_d;
            ac_col_q <= ac_col_d;
        end
    end
    always_comb begin
        last = cnt_q == CW'(SLOT_CYC - 1);
        boundary = state_q == SHOW && last && slot_q == 3'd7;
        state_d = state_q == BLANK ? (cnt_q == CW'(BLANK_CYCLES - 1) ? SHOW : BLANK) : (last ? BLANK : SHOW);
        cnt_d = last ? '0 : cnt_q + 1'b1;
        slot_d = state_q == SHOW && last ? slot_q + 3'd1 : slot_q;
    end
    always_comb begin
        sh_dig_d = sh_dig_q;
        sh_col_d = sh_col_q;
        ac_dig_d = ac_dig_q;
        ac_col_d = ac_col_q;
        if (wr_en && wr_addr[3])
            sh_col_d[wr_addr[2:0]] = wr_data;
        if (wr_en && !wr_addr[3] && !wr_addr[2])
            sh_dig_d[wr_addr[1:0]] = wr_data[5:0];
        // Swap copies the pre-write shadow, so a write on the boundary waits for the next commit
        if (boundary && pending_q) begin
            ac_dig_d = sh_dig_q;
            ac_col_d = sh_col_q;
        end
        pending_d = pending_q ? !boundary : commit;
        frame_done_d = boundary;
        dig = ac_dig_q[slot_q[1:0]];
        led_d = state_q == SHOW ? {dig[5] ? 8'hFF : {~dig[4], SEG[dig[3:0]][6:0]}, ~(4'b0001 << slot_q[1:0])} : 12'hFFF;
        row_d = state_q == SHOW ? ~ac_col_q[slot_q] : 8'hFF;
        col_d = state_q == SHOW ? ~(8'b1 << slot_q) : 8'hFF;
    end
    assign pending = pending_q;
    assign frame_done = frame_done_q;
    assign slot = slot_q;
    assign LED = led_q;
    assign ROW_LED = row_q;
    assign COL_LED = col_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench comparing every output cycle against a frame-time reference model.
module tb_display_scan_ctrl;
    logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, commit = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic pending, frame_done;
    logic [2:0] slot;
    logic [11:0] LED;
    logic [7:0] ROW_LED, COL_LED;
    display_scan_ctrl #(.CLOCK_FREQUENCY(64), .SCAN_RATE(4), .BLANK_CYCLES(2)) dut (
        .CLOCK_IN(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .pending(pending), .frame_done(frame_done), .slot(slot),
        .LED(LED), .ROW_LED(ROW_LED), .COL_LED(COL_LED)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [11:0] led;
        logic [7:0] row;
        logic [7:0] col;
        logic pend;
        logic fd;
        logic [2:0] slot;
    } exp_t;
    exp_t q[$];
    int checks = 0, failures = 0;
    bit done = 0;
    int t = 0;
    bit pend = 0;
    logic [5:0] sd [4], ad [4];
    logic [7:0] sc [8], ac [8];
    logic [7:0] segt [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};
    // One clock of stimulus; t is the position within the 128-cycle frame
    task automatic cyc(input bit r, input bit we, input logic [3:0] a, input logic [7:0] d, input bit cm);
        exp_t e;
        int s, ph;
        logic [5:0] dg;
        logic [7:0] sv;
        @(negedge clk);
        reset = r; wr_en = we; wr_addr = a; wr_data = d; commit = cm;
        e = '{led: 12'hFFF, row: 8'hFF, col: 8'hFF, default: '0};
        if (r) begin
            t = 0;
            pend = 0;
            for (int i = 0; i < 4; i++) begin sd[i] = 6'h20; ad[i] = 6'h20; end
            for (int i = 0; i < 8; i++) begin sc[i] = 8'h00; ac[i] = 8'h00; end
        end else begin
            s = t / 16;
            ph = t % 16;
            if (ph >= 2) begin
                dg = ad[s % 4];
                sv = segt[dg[3:0]];
                e.led = {dg[5] ? 8'hFF : {~dg[4], sv[6:0]}, ~(4'b0001 << (s % 4))};
                e.row = ~ac[s];
                e.col = ~(8'b1 << s);
            end
            e.fd = t == 127;
            if (t == 127 && pend) begin ad = sd; ac = sc; end
            pend = pend ? t != 127 : cm;
            if (we && a >= 8) sc[a - 8] = d;
            if (we && a < 4) sd[a] = d[5:0];
            t = (t + 1) % 128;
            e.pend = pend;
            e.slot = 3'(t / 16);
        end
        q.push_back(e);
    endtask
    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 4'h0, 8'h00, 0);
    endtask
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cyc(0, 1, a, d, 0);
    endtask
    task automatic to_t(input int target);
        while (t != target) idle(1);
    endtask
    initial begin
        exp_t e, g;
        while (!done) begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                g = {LED, ROW_LED, COL_LED, pending, frame_done, slot};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL outputs @%0t: got led=%h row=%h col=%h pend=%b fd=%b slot=%0d, want led=%h row=%h col=%h pend=%b fd=%b slot=%0d",
                             $time, g.led, g.row, g.col, g.pend, g.fd, g.slot, e.led, e.row, e.col, e.pend, e.fd, e.slot);
                end
            end
        end
    end
    initial begin
        repeat (3) cyc(1, 0, 4'h0, 8'h00, 0);
        idle(260);
        wr(4'h0, 8'h05);
        wr(4'h8, 8'h81);
        cyc(0, 0, 4'h0, 8'h00, 1);
        idle(260);
        wr(4'h3, 8'h1C);
        idle(130);
        cyc(0, 0, 4'h0, 8'h00, 1);
        idle(260);
        to_t(127);
        cyc(0, 1, 4'h1, 8'h02, 1);
        idle(260);
        wr(4'h5, 8'hFF);
        cyc(0, 0, 4'h0, 8'h00, 1);
        idle(260);
        wr(4'h9, 8'h3C);
        cyc(0, 1, 4'h2, 8'hEA, 1);
        to_t(4 * 16 + 5);
        cyc(1, 0, 4'h0, 8'h00, 0);
        idle(140);
        repeat (3500)
            cyc($urandom_range(0, 599) == 0, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                8'($urandom), $urandom_range(0, 24) == 0);
        idle(2);
        done = 1;
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d leftover expectations, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 4-digit 7-segment display (LED[11:0]) and 8x8 LED matrix (ROW_LED/COL_LED).
- Holds a double-buffered frame: writers update a shadow buffer; a commit request swaps it to the active buffer at the next frame boundary, so the display never tears.
- Sequences 8 scan slots per frame with an anti-ghosting blank interval at the start of each slot.
- Replaces ad-hoc count-driven pattern logic in top-level display modules.

Parameters:
- CLOCK_FREQUENCY, 50_000_000, input clock frequency in Hz.
- SCAN_RATE, 1000, slot rate in Hz. Slot length SLOT_CYC = CLOCK_FREQUENCY/SCAN_RATE clock cycles.
- BLANK_CYCLES, 16, cycles at the start of each slot with all outputs off. Requires BLANK_CYCLES+1 < SLOT_CYC.

Ports:
- CLOCK_IN  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  single-cycle write strobe into the shadow buffer
- wr_addr  in  4  0-3 = digit 0-3; 8-15 = matrix column 0-7; 4-7 ignored
- wr_data  in  8  digit entry: [3:0] hex value, [4] dp on, [5] blank. Column entry: pixel bitmap, bit r = row r lit
- commit  in  1  request shadow-to-active swap at the next frame boundary
- pending  out  1  swap requested, not yet applied
- frame_done  out  1  one-cycle pulse at the end of slot 7
- slot  out  3  current scan slot
- LED  out  12  [11:4] segments active-low (bit11 = dp, bits10..4 = g..a); [3:0] digit select, active-low one-hot
- ROW_LED  out  8  matrix row drive, active-low (ROW_LED = ~bitmap)
- COL_LED  out  8  matrix column select, active-low one-hot

Behaviour:
- Single clock domain. All outputs registered; outputs reflect the internal state of the previous cycle (1-cycle latency).
- Reset (synchronous, active-high) sets:
  - LED = 12'hFFF, ROW_LED = 8'hFF, COL_LED = 8'hFF.
  - pending = 0, frame_done = 0, slot = 0.
  - Cycle counter = 0; FSM = BLANK.
  - Both buffers: all digits blank ([5]=1), all columns 8'h00.
  - Reset mid-frame or mid-pending discards the pending swap and the buffer contents.
- FSM states and transitions:
  - BLANK: outputs all off (values as at reset). Leave when cycle counter == BLANK_CYCLES-1; go to SHOW.
  - SHOW: drive the current slot s:
    - COL_LED = ~(1<<s); ROW_LED = ~active_col[s].
    - Digit d = s[1:0]: LED[3:0] = ~(1<<d).
    - LED[11:4] = 8'hFF if blank; otherwise {~dp, seg7(hex)}.
    - Leave when cycle counter == SLOT_CYC-1; go to BLANK; slot = slot+1 mod 8 (7 wraps to 0).
  - Each digit is therefore shown twice per frame.
- Cycle counter: width clog2(SLOT_CYC). Counts 0..SLOT_CYC-1, then wraps to 0.
- seg7 table (the 7 bits g..a, shown as active-low {1'b1,gfedcba}):
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, c:A7, d:A1, E:86, F:8E
- Writes: on wr_en, shadow[wr_addr] <= wr_data the same cycle.
  - Digit entries store bits [5:0]; bits [7:6] are ignored.
  - Addresses 4-7 are a no-op.
  - The active buffer is never written directly.
- Commit:
  - commit=1 sets pending the next cycle. Extra commits while pending is set have no effect.
  - Frame boundary = the last cycle of slot 7. At that cycle, if pending=1: active <= shadow, and pending clears the next cycle.
  - frame_done pulses on every boundary, with or without a swap.
- Simultaneous events:
  - wr_en on a boundary cycle with a swap: the copy takes the pre-write shadow. The write stays in shadow only, for the next commit.
  - commit on a boundary cycle while pending=0: not applied at this boundary; pending=1, swap at the following boundary.
  - commit and wr_en in the same cycle: both accepted; the write is included in the eventual swap.

Test Plan (CLOCK_FREQUENCY=64, SCAN_RATE=4, so SLOT_CYC=16; BLANK_CYCLES=2):
1. Reset held 3 cycles, then released:
   - Before the first swap: LED=FFF, COL_LED=FF, ROW_LED=FF, pending=0.
   - slot advances every 16 cycles; frame_done pulses every 128 cycles.
2. Write addr 0 = 8'h05, addr 8 = 8'h81, commit; wait for frame_done:
   - In slot 0 SHOW: LED = 12'h92E, COL_LED = 8'hFE, ROW_LED = 8'h7E.
   - During the first 2 cycles of each slot, all outputs are FF/FFF.
3. Write addr 3 = 8'h1C (dp on, hex c), no commit:
   - Slot 3 still shows the old value.
   - After commit and the boundary: slot 3 LED = 12'h277 and slot 7 LED = 12'h277; pending clears the cycle after the boundary.
4. Assert commit and a wr_en (addr 1 = 8'h02) on the boundary cycle, with pending=0:
   - No swap at this boundary.
   - Next boundary swaps; slot 1 then shows LED = 12'hA4D.
5. Write addr 5 = 8'hFF, then commit:
   - Display is unchanged versus the prior frame; no X on any output.
6. Assert reset mid-slot 4 with pending=1:
   - Next cycle: outputs off, pending=0.
   - Prior frame content is gone: all digits blank, matrix dark.
